// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: samples the PC, runs one req/ack transaction against
// instruction memory and holds the fetched word for decode under valid/ready.
// Latency: ISSUE -> REQ (ack) -> HOLD, so 3 cycles per instruction at best.
// Backpressure: the word is held in HOLD until inst_ready, and pc_advance stays low meanwhile.
//
// Ports:
//   clk, rest                      clock, synchronous active-high reset
//   pc_addr, redirect              current PC and taken-branch/jump pulse from the PC unit
//   imem_req, imem_addr            registered request/address to instruction memory
//   imem_ack, imem_rdata           memory response
//   inst_valid, inst_ready         handshake towards decode
//   inst_out, inst_pc              held instruction word and the address it came from
//   pc_advance                     PC enable (combinational, HOLD handshake only)
//   fetch_err                      sticky memory-timeout flag
//   fetch_count                    delivered-instruction counter (wraps)
module fetch_seq #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rest,
   input  logic [31:0] pc_addr,
   input  logic        redirect,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        pc_advance,
   output logic        fetch_err,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Limit compared against a 16-bit saturating counter; larger values clamp.
   localparam logic [15:0] TMO_LIM = (TIMEOUT > 32'd65535) ? 16'hFFFF : 16'(TIMEOUT);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] tmo_cnt;
   logic [15:0] tmo_inc;
   logic        capture;   // accept imem_rdata into the hold register
   logic        deliver;   // decode took the held word
   logic        waiting;   // outstanding request, no ack this cycle
   logic        unused_pc_lsb;

   // Fetches are word-aligned, so the PC byte offset is dropped.
   assign unused_pc_lsb = ^pc_addr[1:0];

   assign tmo_inc = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;

   always_ff @(posedge clk) begin
      if (rest) begin
         state <= ISSUE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      capture    = 1'b0;
      deliver    = 1'b0;
      waiting    = 1'b0;
      pc_advance = 1'b0;
      case (state)
         ISSUE: begin
            state_nxt = REQ;
         end
         REQ: begin
            waiting = !imem_ack;
            if (redirect) begin
               // The request cannot be retracted: without an ack it must be drained.
               state_nxt = imem_ack ? ISSUE : DRAIN;
            end else if (imem_ack) begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end
         end
         DRAIN: begin
            // Redirects here are ignored; the PC is already pointing at the new target.
            waiting = !imem_ack;
            if (imem_ack) begin
               state_nxt = ISSUE;
            end
         end
         HOLD: begin
            // Redirect wins over a same-cycle handshake.
            if (redirect) begin
               state_nxt = ISSUE;
            end else if (inst_valid && inst_ready) begin
               deliver    = 1'b1;
               pc_advance = !rest;
               state_nxt  = ISSUE;
            end
         end
         default: begin
            state_nxt = ISSUE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         imem_req    <= 1'b0;
         imem_addr   <= 32'd0;
         inst_valid  <= 1'b0;
         inst_out    <= 32'd0;
         inst_pc     <= 32'd0;
         fetch_err   <= 1'b0;
         fetch_count <= 32'd0;
         tmo_cnt     <= 16'd0;
      end else begin
         if (state == ISSUE) begin
            imem_addr <= {pc_addr[31:2], 2'b00};
         end
         // Request is held for the whole REQ/DRAIN span and drops with the ack.
         imem_req   <= (state_nxt == REQ) || (state_nxt == DRAIN);
         inst_valid <= (state_nxt == HOLD);
         if (capture) begin
            inst_out <= imem_rdata;
            inst_pc  <= imem_addr;
         end
         if (deliver) begin
            fetch_count <= fetch_count + 32'd1;
         end
         // Counts only while a request is outstanding; ack or any other state clears it.
         tmo_cnt <= waiting ? tmo_inc : 16'd0;
         if (waiting && (tmo_inc >= TMO_LIM)) begin
            fetch_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a tiny PC model plus per-cycle memory/decode stimulus.
// Inputs change 1 time unit after the rising edge; outputs are checked in the same window.
module tb_fetch_seq;

   logic        clk = 1'b0;
   logic        rest;
   logic [31:0] pc_addr;
   logic        redirect;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        pc_advance;
   logic        fetch_err;
   logic [31:0] fetch_count;

   logic [31:0] redir_pc;
   logic [31:0] reset_pc;
   int          n_checks = 0;
   int          n_errors = 0;

   fetch_seq #(.TIMEOUT(8)) dut (
      .clk         (clk),
      .rest        (rest),
      .pc_addr     (pc_addr),
      .redirect    (redirect),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_out    (inst_out),
      .inst_pc     (inst_pc),
      .pc_advance  (pc_advance),
      .fetch_err   (fetch_err),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   // Program counter: reset value, redirect target, or +4 on pc_advance.
   always @(posedge clk) begin
      if (rest)
         pc_addr <= reset_pc;
      else if (redirect)
         pc_addr <= redir_pc;
      else if (pc_advance)
         pc_addr <= pc_addr + 32'd4;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered in ISSUE with inst_ready=1; memory acks on the first REQ cycle.
   task automatic run_fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                            input logic [31:0] exp_cnt);
      imem_ack = 1'b0;
      #1 check("issue_adv", pc_advance, 1'b0);
      tick();
      check("req_hi", imem_req, 1'b1);
      check("req_addr", imem_addr, exp_addr);
      imem_ack   = 1'b1;
      imem_rdata = word;
      #1 check("req_adv", pc_advance, 1'b0);
      tick();
      imem_ack = 1'b0;
      #1;
      check("hold_valid", inst_valid, 1'b1);
      check("hold_inst", inst_out, word);
      check("hold_pc", inst_pc, exp_addr);
      check("hold_adv", pc_advance, 1'b1);
      tick();
      check("post_valid", inst_valid, 1'b0);
      check("post_count", fetch_count, exp_cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rest       = 1'b1;
      redirect   = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      inst_ready = 1'b1;
      redir_pc   = 32'd0;
      reset_pc   = 32'd0;
      repeat (2) @(posedge clk);
      #1 rest = 1'b0;
      #1;

      // Reset state
      check("rst_req", imem_req, 1'b0);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_inst", inst_out, 32'd0);
      check("rst_ipc", inst_pc, 32'd0);
      check("rst_adv", pc_advance, 1'b0);
      check("rst_err", fetch_err, 1'b0);
      check("rst_count", fetch_count, 32'd0);

      // Sequential fetch from 0x0 and 0x4
      run_fetch(32'h0, 32'h1111_1111, 32'd1);
      run_fetch(32'h4, 32'h2222_2222, 32'd2);

      // Backpressure: 5 HOLD cycles without ready
      inst_ready = 1'b0;
      tick();
      check("bp_addr", imem_addr, 32'h8);
      imem_ack   = 1'b1;
      imem_rdata = 32'h8C01_0004;
      tick();
      imem_ack   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_valid", inst_valid, 1'b1);
         check("bp_inst", inst_out, 32'h8C01_0004);
         check("bp_adv", pc_advance, 1'b0);
         tick();
      end
      inst_ready = 1'b1;
      #1;
      check("bp_release_adv", pc_advance, 1'b1);
      check("bp_ipc", inst_pc, 32'h8);
      tick();
      check("bp_count", fetch_count, 32'd3);
      check("bp_valid_drop", inst_valid, 1'b0);

      // Redirect during a slow request: REQ, REQ(redirect), DRAIN, DRAIN(ack)
      tick();
      check("rd_req1", imem_req, 1'b1);
      check("rd_addr1", imem_addr, 32'hC);
      tick();
      redirect = 1'b1;
      redir_pc = 32'h40;
      tick();
      redirect = 1'b0;
      check("rd_drain_req", imem_req, 1'b1);
      check("rd_drain_valid", inst_valid, 1'b0);
      tick();
      check("rd_drain_req2", imem_req, 1'b1);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      check("rd_discard_valid", inst_valid, 1'b0);
      check("rd_discard_inst", inst_out, 32'h8C01_0004);
      check("rd_discard_req", imem_req, 1'b0);
      check("rd_count", fetch_count, 32'd3);
      tick();
      check("rd_new_addr", imem_addr, 32'h40);
      imem_ack   = 1'b1;
      imem_rdata = 32'h5555_5555;
      tick();
      imem_ack = 1'b0;

      // Redirect together with ready in HOLD
      check("rh_valid", inst_valid, 1'b1);
      check("rh_ipc", inst_pc, 32'h40);
      redirect = 1'b1;
      redir_pc = 32'h80;
      #1 check("rh_adv", pc_advance, 1'b0);
      tick();
      redirect = 1'b0;
      check("rh_valid_drop", inst_valid, 1'b0);
      check("rh_count", fetch_count, 32'd3);
      tick();

      // Timeout: no ack for 8 REQ cycles
      check("to_addr", imem_addr, 32'h80);
      for (int i = 0; i < 8; i++) begin
         check("to_err_low", fetch_err, 1'b0);
         tick();
      end
      check("to_err_high", fetch_err, 1'b1);
      check("to_req_high", imem_req, 1'b1);
      imem_ack   = 1'b1;
      imem_rdata = 32'h7777_7777;
      tick();
      imem_ack = 1'b0;
      check("to_late_valid", inst_valid, 1'b1);
      check("to_late_inst", inst_out, 32'h7777_7777);
      check("to_err_sticky", fetch_err, 1'b1);
      tick();
      check("to_count", fetch_count, 32'd4);
      check("to_err_sticky2", fetch_err, 1'b1);

      // Reset in REQ with an ack in the reset cycle and just after
      reset_pc = 32'h100;
      tick();
      check("mr_req", imem_req, 1'b1);
      check("mr_addr", imem_addr, 32'h84);
      rest       = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h9999_9999;
      tick();
      rest = 1'b0;
      #1;
      check("mr_req0", imem_req, 1'b0);
      check("mr_addr0", imem_addr, 32'd0);
      check("mr_valid0", inst_valid, 1'b0);
      check("mr_inst0", inst_out, 32'd0);
      check("mr_ipc0", inst_pc, 32'd0);
      check("mr_adv0", pc_advance, 1'b0);
      check("mr_err0", fetch_err, 1'b0);
      check("mr_count0", fetch_count, 32'd0);
      tick();
      imem_ack = 1'b0;
      check("mr_refetch_req", imem_req, 1'b1);
      check("mr_refetch_addr", imem_addr, 32'h100);
      check("mr_ack_ignored", inst_valid, 1'b0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hAAAA_AAAA;
      tick();
      imem_ack = 1'b0;
      check("mr_inst", inst_out, 32'hAAAA_AAAA);
      check("mr_ipc", inst_pc, 32'h100);
      tick();
      check("mr_count", fetch_count, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
